// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the LSU, with one access in flight at a time.
// LSU has priority; a fetch that loses STARVE_MAX times in a row is granted on the next arbitration.
//
// state    | meaning
// IDLE     | free; arbitrate and present the winner to memory
// HOLD     | request presented, memory not ready yet; owner is latched
// WAIT_RSP | request accepted; waiting for the single memory response
module mem_port_arbiter #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req_v_i,
  input  logic [XLEN-1:0] if_adr_i,
  output logic            if_gnt_o,
  output logic            if_rsp_v_o,
  output logic [XLEN-1:0] if_rsp_data_o,
  input  logic            ls_req_v_i,
  input  logic [XLEN-1:0] ls_adr_i,
  input  logic            ls_is_store_i,
  input  logic [XLEN-1:0] ls_store_data_i,
  input  logic [2:0]      ls_size_i,
  output logic            ls_gnt_o,
  output logic            ls_rsp_v_o,
  output logic [XLEN-1:0] ls_rsp_data_o,
  input  logic            flush_i,
  output logic            mem_req_v_o,
  input  logic            mem_req_rdy_i,
  output logic [XLEN-1:0] mem_adr_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_wdata_o,
  output logic [2:0]      mem_size_o,
  input  logic            mem_rsp_v_i,
  input  logic [XLEN-1:0] mem_rsp_data_i
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, HOLD, WAIT_RSP} state_t;

  state_t          state, state_nxt;
  logic            owner_if, owner_if_nxt;
  logic            drop;
  logic [SW-1:0]   starve_cnt;
  logic            sel_if, sel_ls, drv_if, req_v;
  logic            hs, rsp_fire, if_emit, ls_emit;

  always_comb begin
    state_nxt    = state;
    owner_if_nxt = owner_if;
    req_v        = 1'b0;
    drv_if       = owner_if;
    sel_if       = if_req_v_i & (~ls_req_v_i | (starve_cnt == SW'(STARVE_MAX)));
    sel_ls       = ~sel_if & ls_req_v_i;
    case (state)
      IDLE: begin
        if (sel_if | sel_ls) begin
          req_v        = 1'b1;
          drv_if       = sel_if;
          owner_if_nxt = sel_if;
          state_nxt    = mem_req_rdy_i ? WAIT_RSP : HOLD;
        end
      end
      HOLD: begin
        // owner stays latched even if its requester withdraws
        req_v = 1'b1;
        if (mem_req_rdy_i) state_nxt = WAIT_RSP;
      end
      WAIT_RSP: begin
        if (mem_rsp_v_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign hs          = req_v & mem_req_rdy_i;
  assign if_gnt_o    = hs & drv_if;
  assign ls_gnt_o    = hs & ~drv_if;
  assign mem_req_v_o = req_v;
  assign mem_adr_o   = !req_v ? '0 : (drv_if ? if_adr_i : ls_adr_i);
  assign mem_we_o    = req_v & ~drv_if & ls_is_store_i;
  assign mem_wdata_o = (req_v & ~drv_if) ? ls_store_data_i : '0;
  assign mem_size_o  = !req_v ? 3'b000 : (drv_if ? 3'b010 : ls_size_i);

  // a flush arriving with the response still kills a fetch response
  assign rsp_fire = (state == WAIT_RSP) & mem_rsp_v_i;
  assign if_emit  = rsp_fire & owner_if & ~drop & ~flush_i;
  assign ls_emit  = rsp_fire & ~owner_if;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      owner_if      <= 1'b0;
      drop          <= 1'b0;
      starve_cnt    <= '0;
      if_rsp_v_o    <= 1'b0;
      ls_rsp_v_o    <= 1'b0;
      if_rsp_data_o <= '0;
      ls_rsp_data_o <= '0;
    end else begin
      state      <= state_nxt;
      owner_if   <= owner_if_nxt;
      if_rsp_v_o <= if_emit;
      ls_rsp_v_o <= ls_emit;
      if (if_emit) if_rsp_data_o <= mem_rsp_data_i;
      if (ls_emit) ls_rsp_data_o <= mem_rsp_data_i;
      if (state == IDLE || rsp_fire) drop <= 1'b0;
      else if (owner_if && flush_i)  drop <= 1'b1;
      if (if_gnt_o) starve_cnt <= '0;
      else if (ls_gnt_o && if_req_v_i && starve_cnt != SW'(STARVE_MAX))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus a random phase against a transaction-level reference of the port arbiter.
module tb_mem_port_arbiter;
  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req_v_i, if_gnt_o, if_rsp_v_o;
  logic [31:0] if_adr_i, if_rsp_data_o;
  logic        ls_req_v_i, ls_is_store_i, ls_gnt_o, ls_rsp_v_o;
  logic [31:0] ls_adr_i, ls_store_data_i, ls_rsp_data_o;
  logic [2:0]  ls_size_i, mem_size_o;
  logic        flush_i, mem_req_v_o, mem_req_rdy_i, mem_we_o, mem_rsp_v_i;
  logic [31:0] mem_adr_o, mem_wdata_o, mem_rsp_data_i;

  always #5 clk = ~clk;

  mem_port_arbiter #(.XLEN(32), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .if_req_v_i(if_req_v_i), .if_adr_i(if_adr_i), .if_gnt_o(if_gnt_o),
    .if_rsp_v_o(if_rsp_v_o), .if_rsp_data_o(if_rsp_data_o),
    .ls_req_v_i(ls_req_v_i), .ls_adr_i(ls_adr_i), .ls_is_store_i(ls_is_store_i),
    .ls_store_data_i(ls_store_data_i), .ls_size_i(ls_size_i), .ls_gnt_o(ls_gnt_o),
    .ls_rsp_v_o(ls_rsp_v_o), .ls_rsp_data_o(ls_rsp_data_o), .flush_i(flush_i),
    .mem_req_v_o(mem_req_v_o), .mem_req_rdy_i(mem_req_rdy_i), .mem_adr_o(mem_adr_o),
    .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o), .mem_size_o(mem_size_o),
    .mem_rsp_v_i(mem_rsp_v_i), .mem_rsp_data_i(mem_rsp_data_i)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // stimulus knobs
  int p_if = 0, p_ls = 0, p_flush = 0, rdy_pct = 100, lat_min = 1, lat_max = 1;
  bit fixed_en = 1'b0;
  logic [31:0] fixed_data = 32'h0;

  // memory: one response owed, lat cycles after acceptance
  int mem_cnt = 0;
  logic [31:0] mem_data_q = 32'h0;

  // reference: port reserved by a presented request / by an accepted access
  bit m_pend = 1'b0, m_outst = 1'b0, m_own_if = 1'b0, m_drop = 1'b0;
  int m_starve = 0;
  bit e_if_rsp = 1'b0, e_ls_rsp = 1'b0;
  logic [31:0] e_if_data = 32'h0, e_ls_data = 32'h0;

  bit seen_if_gnt, seen_ls_gnt, seen_if_rsp, seen_ls_rsp, seen_we;
  logic [31:0] seen_adr, seen_wdata, seen_if_data, seen_ls_data;
  logic [2:0]  seen_size;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s at %0t: observed %h expected %h", tag, $time, obs, want);
    end
  endtask

  task automatic cycle();
    bit free, sel_if, e_req, own_if, hs, fire;
    logic [31:0] e_adr, e_wd;
    logic [2:0] e_sz;
    @(negedge clk);
    free   = !m_pend && !m_outst;
    sel_if = if_req_v_i && (!ls_req_v_i || m_starve == SMAX);
    own_if = free ? sel_if : m_own_if;
    e_req  = free ? (if_req_v_i || ls_req_v_i) : m_pend;
    hs     = e_req && mem_req_rdy_i;
    e_adr  = !e_req ? 32'h0 : (own_if ? if_adr_i : ls_adr_i);
    e_wd   = (e_req && !own_if) ? ls_store_data_i : 32'h0;
    e_sz   = !e_req ? 3'b000 : (own_if ? 3'b010 : ls_size_i);
    chk("mem_req_v", 32'(mem_req_v_o), 32'(e_req));
    chk("if_gnt", 32'(if_gnt_o), 32'(hs && own_if));
    chk("ls_gnt", 32'(ls_gnt_o), 32'(hs && !own_if));
    chk("mem_adr", mem_adr_o, e_adr);
    chk("mem_we", 32'(mem_we_o), 32'(e_req && !own_if && ls_is_store_i));
    chk("mem_wdata", mem_wdata_o, e_wd);
    chk("mem_size", 32'(mem_size_o), 32'(e_sz));
    chk("if_rsp_v", 32'(if_rsp_v_o), 32'(e_if_rsp));
    chk("ls_rsp_v", 32'(ls_rsp_v_o), 32'(e_ls_rsp));
    if (e_if_rsp) chk("if_rsp_data", if_rsp_data_o, e_if_data);
    if (e_ls_rsp) chk("ls_rsp_data", ls_rsp_data_o, e_ls_data);
    seen_if_gnt = if_gnt_o;  seen_ls_gnt = ls_gnt_o;
    seen_if_rsp = if_rsp_v_o; seen_ls_rsp = ls_rsp_v_o;
    seen_if_data = if_rsp_data_o; seen_ls_data = ls_rsp_data_o;
    seen_adr = mem_adr_o; seen_we = mem_we_o; seen_wdata = mem_wdata_o; seen_size = mem_size_o;
    @(posedge clk);
    fire = m_outst && mem_rsp_v_i;
    if (reset) begin
      m_pend = 0; m_outst = 0; m_own_if = 0; m_drop = 0; m_starve = 0;
      e_if_rsp = 0; e_ls_rsp = 0;
    end else begin
      e_if_rsp = fire && m_own_if && !m_drop && !flush_i;
      e_ls_rsp = fire && !m_own_if;
      if (e_if_rsp) e_if_data = mem_rsp_data_i;
      if (e_ls_rsp) e_ls_data = mem_rsp_data_i;
      if (hs && own_if) m_starve = 0;
      else if (hs && !own_if && if_req_v_i && m_starve < SMAX) m_starve++;
      if (free || fire) m_drop = 0;
      else if (m_own_if && flush_i) m_drop = 1;
      if (free && e_req) m_own_if = own_if;
      if (fire) m_outst = 0;
      else if (hs) begin m_outst = 1; m_pend = 0; end
      else if (e_req) m_pend = 1;
    end
    #1;
    if (hs) begin
      mem_cnt    = $urandom_range(lat_max, lat_min);
      mem_data_q = fixed_en ? fixed_data : $urandom();
    end else if (mem_cnt > 0) mem_cnt--;
    mem_rsp_v_i    = (mem_cnt == 1);
    mem_rsp_data_i = mem_rsp_v_i ? mem_data_q : 32'h0;
    if (hs && own_if) if_req_v_i = 1'b0;
    if (hs && !own_if) ls_req_v_i = 1'b0;
    if (!if_req_v_i && $urandom_range(99) < p_if) begin
      if_req_v_i = 1'b1;
      if_adr_i   = $urandom() & 32'hFFFF_FFFC;
    end
    if (!ls_req_v_i && $urandom_range(99) < p_ls) begin
      ls_req_v_i      = 1'b1;
      ls_adr_i        = $urandom();
      ls_is_store_i   = $urandom_range(1);
      ls_store_data_i = $urandom();
      ls_size_i       = 3'($urandom_range(2));
    end
    if (p_flush > 0) flush_i = ($urandom_range(99) < p_flush);
    mem_req_rdy_i = ($urandom_range(99) < rdy_pct);
  endtask

  task automatic drain();
    bit done;
    p_if = 0; p_ls = 0; p_flush = 0; flush_i = 1'b0; rdy_pct = 100;
    done = 1'b0;
    for (int k = 0; k < 60; k++) begin
      done = !if_req_v_i && !ls_req_v_i && mem_cnt == 0 && !m_pend && !m_outst;
      if (done) break;
      cycle();
    end
    chk("drain_done", 32'(done), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int gnt_c, rsp_c, cnt;
    logic [31:0] data;
    bit got[$];

    reset = 1'b1; flush_i = 1'b0; mem_req_rdy_i = 1'b1; mem_rsp_v_i = 1'b0; mem_rsp_data_i = 32'h0;
    if_req_v_i = 1'b0; if_adr_i = 32'h0; ls_req_v_i = 1'b0; ls_adr_i = 32'h0;
    ls_is_store_i = 1'b0; ls_store_data_i = 32'h0; ls_size_i = 3'b000;
    cycle(); cycle();
    reset = 1'b0;
    cycle();
    chk("rst_if_data", if_rsp_data_o, 32'h0);
    chk("rst_ls_data", ls_rsp_data_o, 32'h0);

    // 1: LSU load, response two cycles after acceptance
    fixed_en = 1'b1; fixed_data = 32'hDEADBEEF; lat_min = 2; lat_max = 2;
    ls_req_v_i = 1'b1; ls_adr_i = 32'h100; ls_is_store_i = 1'b0; ls_size_i = 3'b010;
    gnt_c = -1; rsp_c = -1; data = 32'h0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (seen_ls_gnt && gnt_c < 0) gnt_c = i;
      if (seen_ls_rsp && rsp_c < 0) begin rsp_c = i; data = seen_ls_data; end
    end
    chk("t1_gnt_cycle", 32'(gnt_c), 32'd0);
    chk("t1_rsp_cycle", 32'(rsp_c), 32'd3);
    chk("t1_rsp_data", data, 32'hDEADBEEF);
    drain();

    // 2: both requesters always busy, 1-cycle memory
    fixed_en = 1'b0; lat_min = 1; lat_max = 1;
    if_req_v_i = 1'b1; if_adr_i = 32'h1000; ls_req_v_i = 1'b1; ls_adr_i = 32'h2000;
    p_if = 100; p_ls = 100;
    for (int i = 0; i < 32; i++) begin
      cycle();
      if (seen_if_gnt) got.push_back(1'b1);
      else if (seen_ls_gnt) got.push_back(1'b0);
    end
    chk("t2_grant_count", 32'(got.size() >= 10), 32'd1);
    for (int k = 0; k < 10 && k < got.size(); k++)
      chk("t2_grant_seq", 32'(got[k]), 32'((k % 5) == 4));
    drain();

    // 3: fetch held by memory backpressure, LSU arrives meanwhile
    lat_min = 2; lat_max = 2;
    if_req_v_i = 1'b1; if_adr_i = 32'h40; mem_req_rdy_i = 1'b0; rdy_pct = 0;
    cycle(); chk("t3_hold_adr", seen_adr, 32'h40);
    ls_req_v_i = 1'b1; ls_adr_i = 32'h300; ls_is_store_i = 1'b0; ls_size_i = 3'b001;
    cycle(); chk("t3_hold_adr", seen_adr, 32'h40);
    chk("t3_no_ls_gnt", 32'(seen_ls_gnt), 32'd0);
    rdy_pct = 100;
    cycle(); chk("t3_hold_adr", seen_adr, 32'h40);
    gnt_c = -1; rsp_c = -1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (seen_ls_gnt && gnt_c < 0) gnt_c = i;
      if (seen_if_rsp && rsp_c < 0) rsp_c = i;
    end
    chk("t3_if_rsp_cycle", 32'(rsp_c), 32'd3);
    chk("t3_ls_gnt_cycle", 32'(gnt_c), 32'd3);
    drain();

    // 4: flush while a fetch waits for data, then a clean fetch
    fixed_en = 1'b1; fixed_data = 32'h1234; lat_min = 3; lat_max = 3;
    if_req_v_i = 1'b1; if_adr_i = 32'h80;
    cycle();
    flush_i = 1'b1; cycle(); flush_i = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin cycle(); if (seen_if_rsp) cnt++; end
    chk("t4_flushed_rsp", 32'(cnt), 32'd0);
    fixed_data = 32'hCAFE0001; if_req_v_i = 1'b1; if_adr_i = 32'hC0;
    cnt = 0; data = 32'h0;
    for (int i = 0; i < 7; i++) begin
      cycle();
      if (seen_if_rsp) begin cnt++; data = seen_if_data; end
    end
    chk("t4_next_rsp_cnt", 32'(cnt), 32'd1);
    chk("t4_next_rsp_data", data, 32'hCAFE0001);
    drain();

    // 5: LSU store
    ls_req_v_i = 1'b1; ls_adr_i = 32'h200; ls_is_store_i = 1'b1;
    ls_store_data_i = 32'hA5A5A5A5; ls_size_i = 3'b010; lat_min = 1; lat_max = 1;
    cycle();
    chk("t5_we", 32'(seen_we), 32'd1);
    chk("t5_wdata", seen_wdata, 32'hA5A5A5A5);
    chk("t5_size", 32'(seen_size), 32'd2);
    cnt = 0; gnt_c = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (seen_ls_rsp) cnt++;
      if (seen_if_rsp) gnt_c++;
    end
    chk("t5_ls_ack", 32'(cnt), 32'd1);
    chk("t5_no_if_rsp", 32'(gnt_c), 32'd0);
    drain();

    // 6: reset in the middle of an access, stale response afterwards
    lat_min = 3; lat_max = 3;
    if_req_v_i = 1'b1; if_adr_i = 32'h500;
    cycle(); cycle();
    reset = 1'b1; cycle(); reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (seen_if_rsp || seen_ls_rsp) cnt++;
    end
    chk("t6_no_pulse", 32'(cnt), 32'd0);
    chk("t6_if_data", if_rsp_data_o, 32'h0);
    chk("t6_ls_data", ls_rsp_data_o, 32'h0);
    lat_min = 1; lat_max = 1;
    ls_req_v_i = 1'b1; ls_adr_i = 32'h600; ls_is_store_i = 1'b0;
    cycle();
    chk("t6_idle_gnt", 32'(seen_ls_gnt), 32'd1);
    drain();

    // random traffic with backpressure, flushes and variable latency
    fixed_en = 1'b0; lat_min = 1; lat_max = 3;
    p_if = 40; p_ls = 40; p_flush = 15; rdy_pct = 60;
    for (int i = 0; i < 2000; i++) cycle();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
